// File: rtl/tone_fm_pkg.sv
// Shared constants and types for the tone FM receiver: note table, tolerance and FSM states.
package tone_fm_pkg;

    localparam int unsigned NUM_NOTES = 8;
    localparam int unsigned TOL_SHIFT = 5;
    localparam longint unsigned REF_CLK_HZ = 64'd50_000_000;

    typedef logic [2:0] note_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_LOCKED
    } rx_state_t;

    // Nominal C4..C5 periods at REF_CLK_HZ; other clocks rescale from this table.
    localparam int unsigned NOM_PERIOD [0:NUM_NOTES-1] = '{
        191113, 170262, 151685, 143173, 127551, 113636, 101238, 95556
    };

    function automatic int unsigned nom_period(input int unsigned clk_hz, input int unsigned k);
        longint unsigned prod;
        prod = 64'(NOM_PERIOD[k]) * 64'(clk_hz) / REF_CLK_HZ;
        return 32'(prod);
    endfunction

endpackage

// File: rtl/tone_fm_rx_classify.sv
// Combinational period classifier: matches a measured period against the note table.
module tone_period_classify
    import tone_fm_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned PERIOD_W    = 20
) (
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_match,
    output note_code_t          o_code
);

    logic [NUM_NOTES-1:0] w_hit;

    for (genvar k = 0; k < NUM_NOTES; k++) begin : g_bin
        localparam int unsigned NOM = nom_period(CLK_FREQ_HZ, k);
        localparam int unsigned LO  = NOM - (NOM >> TOL_SHIFT);
        localparam int unsigned HI  = NOM + (NOM >> TOL_SHIFT);
        assign w_hit[k] = (32'(i_period) >= LO) && (32'(i_period) <= HI);
    end

    // Scan from the top so the lowest matching code is the last one written.
    always_comb begin
        o_match = |w_hit;
        o_code  = '0;
        for (int unsigned k = 0; k < NUM_NOTES; k++) begin
            if (w_hit[NUM_NOTES-1-k]) begin
                o_code = 3'(NUM_NOTES-1-k);
            end
        end
    end

endmodule

// File: rtl/tone_fm_rx.sv
// Tone FM receiver: synchronises a square-wave tone, measures its period and locks onto
// a C-major scale note after STABLE_COUNT consistent periods; times out to silence.
module tone_fm_rx
    import tone_fm_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned PERIOD_W     = 20,
    parameter int unsigned STABLE_COUNT = 3,
    parameter int unsigned SILENCE_CLKS = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                tone_in,
    output logic                note_valid,
    output logic [2:0]          note_index,
    output logic                note_strobe,
    output logic                end_strobe,
    output logic                silence,
    output logic [PERIOD_W-1:0] period_out
);

    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
    localparam logic [PERIOD_W-1:0] SIL_CNT = PERIOD_W'(SILENCE_CLKS);
    localparam logic [3:0]          STABLE  = 4'(STABLE_COUNT);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev;
    logic                w_edge;
    logic [PERIOD_W-1:0] r_cnt;
    rx_state_t           r_state;
    note_code_t          r_cand;
    logic                r_cand_valid;
    logic [3:0]          r_stable;
    logic                w_match;
    note_code_t          w_code;
    logic                w_same;
    logic [3:0]          w_next_stable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= tone_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_prev;

    tone_period_classify #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .PERIOD_W   (PERIOD_W)
    ) u_classify (
        .i_period(r_cnt),
        .o_match (w_match),
        .o_code  (w_code)
    );

    assign w_same = w_match && r_cand_valid && (w_code == r_cand);

    always_comb begin
        w_next_stable = '0;
        if (w_same) begin
            w_next_stable = r_stable + 4'd1;
        end else if (w_match) begin
            w_next_stable = 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_cand       <= '0;
            r_cand_valid <= 1'b0;
            r_stable     <= '0;
            note_valid   <= 1'b0;
            note_index   <= '0;
            note_strobe  <= 1'b0;
            end_strobe   <= 1'b0;
            silence      <= 1'b1;
            period_out   <= '0;
        end else begin
            note_strobe <= 1'b0;
            end_strobe  <= 1'b0;
            if (!enable) begin
                r_state      <= ST_IDLE;
                r_cnt        <= '0;
                r_cand_valid <= 1'b0;
                r_stable     <= '0;
                note_valid   <= 1'b0;
                silence      <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        silence    <= 1'b1;
                        note_valid <= 1'b0;
                        r_cnt      <= '0;
                        if (w_edge) begin
                            r_state      <= ST_ACQ;
                            r_cnt        <= {{(PERIOD_W-1){1'b0}}, 1'b1};
                            r_cand_valid <= 1'b0;
                            r_stable     <= '0;
                            silence      <= 1'b0;
                        end
                    end
                    ST_ACQ, ST_LOCKED: begin
                        if (w_edge) begin
                            period_out <= r_cnt;
                            r_cnt      <= {{(PERIOD_W-1){1'b0}}, 1'b1};
                            // A locked note repeating itself changes nothing; anything else reseeds.
                            if (!(r_state == ST_LOCKED && w_same)) begin
                                r_stable     <= w_next_stable;
                                r_cand_valid <= w_match;
                                if (w_match) begin
                                    r_cand <= w_code;
                                end
                                if (w_next_stable == STABLE) begin
                                    r_state     <= ST_LOCKED;
                                    note_index  <= w_code;
                                    note_valid  <= 1'b1;
                                    note_strobe <= 1'b1;
                                end else begin
                                    r_state    <= ST_ACQ;
                                    note_valid <= 1'b0;
                                end
                            end
                        end else if (r_cnt == SIL_CNT) begin
                            r_state      <= ST_IDLE;
                            r_cnt        <= '0;
                            r_cand_valid <= 1'b0;
                            r_stable     <= '0;
                            note_valid   <= 1'b0;
                            silence      <= 1'b1;
                            end_strobe   <= (r_state == ST_LOCKED);
                        end else if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
